// File: rtl/dev_timer_pkg.sv
// Shared definitions for the device-latency timer: opcodes, channel opcode
// table and FSM state encoding.
package dev_timer_pkg;

  localparam logic [5:0] HDTOINST = 6'b100011;
  localparam logic [5:0] HDTOREG  = 6'b100100;
  localparam logic [5:0] REGTOHD  = 6'b100101;

  localparam int CH_HD  = 0;
  localparam int MAX_CH = 8;

  // Entry i is the single opcode of channel i; entry 0 is unused because
  // the HD channel owns the three opcodes above.
  localparam logic [MAX_CH-1:0][5:0] CH_OPC = {
    6'b101101, 6'b101100, 6'b101011, 6'b101010,
    6'b101001, 6'b100111, 6'b100110, 6'b000000
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/dev_timer_if.sv
// Decoder/control-unit side bundle of the device-latency timer.
interface dev_timer_if #(
  parameter int N_CH   = 4,
  parameter int LAT_W  = 16,
  parameter int STAT_W = 32
);
  localparam int CH_W = $clog2(N_CH);

  logic              is_act;
  logic [5:0]        opcode;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [LAT_W-1:0]  cfg_lat;
  logic              stat_clr;
  logic              ready;
  logic              busy;
  logic              done;
  logic              is_dev_op;
  logic [CH_W-1:0]   cur_ch;
  logic [STAT_W-1:0] stall_cnt;

  modport master (
    output is_act, opcode, cfg_we, cfg_ch, cfg_lat, stat_clr,
    input  ready, busy, done, is_dev_op, cur_ch, stall_cnt
  );

  modport slave (
    input  is_act, opcode, cfg_we, cfg_ch, cfg_lat, stat_clr,
    output ready, busy, done, is_dev_op, cur_ch, stall_cnt
  );
endinterface

// File: rtl/dev_timer_op_decode.sv
// Opcode to device-channel decode; purely combinational so the instruction
// decoder can reuse it.
module dev_op_decode
  import dev_timer_pkg::*;
#(
  parameter int N_CH = 4,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic [5:0]      opcode,
  output logic            is_dev_op,
  output logic [CH_W-1:0] ch
);

  always_comb begin
    is_dev_op = 1'b0;
    ch        = '0;
    if (opcode == HDTOINST || opcode == HDTOREG || opcode == REGTOHD) begin
      is_dev_op = 1'b1;
      ch        = CH_W'(CH_HD);
    end else begin
      for (int i = 1; i < N_CH && i < MAX_CH; i++) begin
        if (opcode == CH_OPC[i]) begin
          is_dev_op = 1'b1;
          ch        = CH_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/dev_timer.sv
// Multi-channel device-latency timer: stalls ready for the decoded channel's
// programmed latency, pulses done, and keeps a saturating stall statistic.
module dev_timer
  import dev_timer_pkg::*;
#(
  parameter int N_CH    = 4,
  parameter int LAT_W   = 16,
  parameter int HD_LAT  = 4,
  parameter int DEF_LAT = 1,
  parameter int STAT_W  = 32
) (
  input  logic      clk,
  input  logic      rst_n,
  dev_timer_if.slave bus
);
  localparam int CH_W = $clog2(N_CH);

  logic [LAT_W-1:0]  lat [N_CH];
  logic              dec_vld;
  logic [CH_W-1:0]   dec_ch;
  logic [LAT_W-1:0]  lat_sel, lat_eff;
  logic [LAT_W-1:0]  cnt;
  logic [CH_W-1:0]   cur_ch;
  logic [STAT_W-1:0] stall_cnt;
  logic              start;
  state_e            state, state_nxt;

  dev_op_decode #(.N_CH(N_CH)) u_dec (
    .opcode    (bus.opcode),
    .is_dev_op (dec_vld),
    .ch        (dec_ch)
  );

  // A write landing in a start cycle is seen only by the next start, since
  // the start samples lat[] before the edge.
  for (genvar g = 0; g < N_CH; g++) begin : g_lat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        lat[g] <= (g == CH_HD) ? LAT_W'(HD_LAT) : LAT_W'(DEF_LAT);
      else if (bus.cfg_we && bus.cfg_ch == CH_W'(g))
        lat[g] <= bus.cfg_lat;
    end
  end

  assign lat_sel = lat[dec_ch];
  assign lat_eff = (lat_sel == '0) ? LAT_W'(1) : lat_sel;
  assign start   = bus.is_act & dec_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!bus.is_act) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (dec_vld) state_nxt = (lat_eff == LAT_W'(1)) ? DONE : WAIT;
        WAIT:    if (cnt == LAT_W'(1)) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // IDLE ready is combinational on the decode so a back-to-back op never
  // lets a spurious ready through.
  always_comb begin
    bus.ready = 1'b1;
    bus.done  = 1'b0;
    case (state)
      IDLE:    bus.ready = ~start;
      WAIT:    bus.ready = ~bus.is_act;
      DONE:    bus.done  = bus.is_act;
      default: ;
    endcase
  end

  assign bus.busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      cur_ch <= '0;
    end else if (!bus.is_act) begin
      cnt <= '0;
    end else if (state == IDLE && dec_vld) begin
      cnt    <= lat_eff - LAT_W'(1);
      cur_ch <= dec_ch;
    end else if (state == WAIT && cnt != LAT_W'(1)) begin
      cnt <= cnt - LAT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (bus.stat_clr)
      stall_cnt <= '0;
    else if (bus.is_act && !bus.ready && !(&stall_cnt))
      stall_cnt <= stall_cnt + STAT_W'(1);
  end

  assign bus.cur_ch    = cur_ch;
  assign bus.stall_cnt = stall_cnt;
  assign bus.is_dev_op = dec_vld;

endmodule

// File: tb/tb_dev_timer.sv
// Randomized and directed bench for dev_timer against a time-based reference
// model: an op started at cycle t0 with latency L stalls t0..t0+L-1, done at t0+L.
module tb_dev_timer;
  localparam int N_CH    = 3;
  localparam int LAT_W   = 16;
  localparam int HD_LAT  = 4;
  localparam int DEF_LAT = 1;
  localparam int STAT_W  = 4;
  localparam int STAT_MAX = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dev_timer_if #(.N_CH(N_CH), .LAT_W(LAT_W), .STAT_W(STAT_W)) bus ();

  dev_timer #(
    .N_CH(N_CH), .LAT_W(LAT_W), .HD_LAT(HD_LAT), .DEF_LAT(DEF_LAT), .STAT_W(STAT_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // reference model state
  bit op_on;
  int op_t0, op_len, cur_ch_m, stall_m;
  int lat_m [N_CH];

  logic [5:0] op_pool [8];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic void ref_dec(input logic [5:0] op, output bit dv, output int ch);
    dv = 1'b0;
    ch = 0;
    case (op)
      6'b100011, 6'b100100, 6'b100101: begin dv = 1'b1; ch = 0; end
      6'b100110: begin dv = 1'b1; ch = 1; end
      6'b100111: begin dv = 1'b1; ch = 2; end
      default: ;
    endcase
  endfunction

  task automatic model_reset();
    op_on    = 1'b0;
    cur_ch_m = 0;
    stall_m  = 0;
    for (int i = 0; i < N_CH; i++) lat_m[i] = (i == 0) ? HD_LAT : DEF_LAT;
  endtask

  // Called at posedge+1 with this cycle's inputs applied; checks, then advances.
  task automatic cycle();
    bit dv;
    int ch, age;
    bit e_rdy, e_busy, e_done;
    int e_cur;
    #1;
    ref_dec(bus.opcode, dv, ch);
    if (!rst_n) model_reset();
    e_cur  = cur_ch_m;
    e_busy = 1'b0;
    e_done = 1'b0;
    e_rdy  = 1'b1;
    if (!rst_n) begin
      e_rdy = !(bus.is_act && dv);
    end else if (op_on) begin
      age    = cyc - op_t0;
      e_busy = 1'b1;
      if (!bus.is_act) begin
        op_on = 1'b0;
      end else if (age < op_len) begin
        e_rdy = 1'b0;
      end else begin
        e_done = 1'b1;
        op_on  = 1'b0;
      end
    end else begin
      e_rdy = !(bus.is_act && dv);
      if (bus.is_act && dv) begin
        op_on    = 1'b1;
        op_t0    = cyc;
        op_len   = (lat_m[ch] == 0) ? 1 : lat_m[ch];
        cur_ch_m = ch;
      end
    end
    chk("ready",     32'(bus.ready),     32'(e_rdy));
    chk("busy",      32'(bus.busy),      32'(e_busy));
    chk("done",      32'(bus.done),      32'(e_done));
    chk("is_dev_op", 32'(bus.is_dev_op), 32'(dv));
    chk("cur_ch",    32'(bus.cur_ch),    32'(e_cur));
    chk("stall_cnt", 32'(bus.stall_cnt), 32'(stall_m));
    if (rst_n) begin
      if (bus.stat_clr) stall_m = 0;
      else if (bus.is_act && !e_rdy && stall_m < STAT_MAX) stall_m++;
      if (bus.cfg_we && int'(bus.cfg_ch) < N_CH) lat_m[bus.cfg_ch] = int'(bus.cfg_lat);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cfg(input int ch, input int lat);
    bus.is_act  = 1'b0;
    bus.cfg_we  = 1'b1;
    bus.cfg_ch  = ch[1:0];
    bus.cfg_lat = lat[LAT_W-1:0];
    cycle();
    bus.cfg_we  = 1'b0;
  endtask

  initial begin
    op_pool[0] = 6'b100011; op_pool[1] = 6'b100100; op_pool[2] = 6'b100101;
    op_pool[3] = 6'b100110; op_pool[4] = 6'b100111; op_pool[5] = 6'b101001;
    op_pool[6] = 6'b000000; op_pool[7] = 6'b111111;
    model_reset();
    rst_n = 1'b0;
    bus.is_act = 1'b0; bus.opcode = '0; bus.cfg_we = 1'b0;
    bus.cfg_ch = '0; bus.cfg_lat = '0; bus.stat_clr = 1'b0;
    @(posedge clk);
    #1;
    run(2);
    bus.is_act = 1'b1; bus.opcode = 6'b100011;
    run(1);
    rst_n = 1'b1;

    // HD op with reset latency 4
    run(5);
    chk("hd_stall_total", 32'(bus.stall_cnt), 32'd4);
    bus.is_act = 1'b0;
    run(1);

    // latency 1, then latency 0 treated as 1
    cfg(0, 1);
    bus.is_act = 1'b1; bus.opcode = 6'b100100;
    run(3);
    bus.is_act = 1'b0;
    run(1);
    cfg(0, 0);
    bus.is_act = 1'b1; bus.opcode = 6'b100100;
    run(3);

    // two back-to-back REGTOHD ops, L=3
    bus.stat_clr = 1'b1;
    cfg(0, 3);
    bus.stat_clr = 1'b0;
    bus.is_act = 1'b1; bus.opcode = 6'b100101;
    run(8);
    chk("b2b_stall_total", 32'(bus.stall_cnt), 32'd6);
    bus.is_act = 1'b0;
    run(1);

    // abort in the second WAIT cycle of an L=8 op, then full restart
    cfg(0, 8);
    bus.is_act = 1'b1; bus.opcode = 6'b100011;
    run(2);
    bus.is_act = 1'b0;
    run(1);
    bus.is_act = 1'b1;
    run(10);
    bus.is_act = 1'b0;
    run(1);

    // write in the start cycle: old latency 4 applies, new 10 next time
    cfg(0, 4);
    bus.is_act = 1'b1; bus.opcode = 6'b100011;
    bus.cfg_we = 1'b1; bus.cfg_ch = 2'd0; bus.cfg_lat = 16'd10;
    run(1);
    bus.cfg_we = 1'b0;
    run(16);
    bus.is_act = 1'b0;
    run(1);

    // out-of-range channel write must leave channels 0..2 alone
    cfg(3, 7);
    bus.is_act = 1'b1; bus.opcode = 6'b100111;
    run(3);

    // saturation and clear-over-increment
    cfg(0, 20);
    bus.is_act = 1'b1; bus.opcode = 6'b100011;
    run(20);
    chk("stall_sat", 32'(bus.stall_cnt), 32'(STAT_MAX));
    bus.stat_clr = 1'b1;
    run(1);
    bus.stat_clr = 1'b0;
    run(3);
    bus.is_act = 1'b0;
    run(1);

    // reset mid-op: lat returns to HD_LAT and the op restarts from IDLE
    cfg(0, 8);
    bus.is_act = 1'b1; bus.opcode = 6'b100011;
    run(3);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(12);

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      bus.is_act   = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 3) == 0) bus.opcode = op_pool[$urandom_range(0, 7)];
      bus.cfg_we   = ($urandom_range(0, 15) == 0);
      bus.cfg_ch   = 2'($urandom_range(0, 3));
      bus.cfg_lat  = 16'($urandom_range(0, 5));
      bus.stat_clr = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/dev_timer.md
# dev_timer

Parametrised multi-channel device-latency timer; successor to the single-channel HD wait counter. Decodes the current opcode into a device channel and holds `ready` low for that channel's programmable latency. It then pulses `ready`/`done` for one cycle so the control unit advances the instruction. Sits between the instruction decoder and the control unit's stall input, and keeps a saturating stall-cycle statistic.

## Interface
- `N_CH`, 4: number of device channels, at least 2; `CH_W = $clog2(N_CH)`.
- `LAT_W`, 16: latency register and counter width.
- `HD_LAT`, 4: reset latency of channel 0 (HD); production builds set 16384.
- `DEF_LAT`, 1: reset latency of channels 1..N_CH-1.
- `STAT_W`, 32: stall-statistic width.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `is_act`  in  1  CPU active. While low: timer forced idle, `ready`=1.
- `opcode`  in  6  opcode of the instruction currently executing.
- `cfg_we`  in  1  latency-register write strobe.
- `cfg_ch`  in  CH_W  channel to write.
- `cfg_lat`  in  LAT_W  new latency in cycles; 0 is treated as 1.
- `stat_clr`  in  1  synchronous clear of `stall_cnt`.
- `ready`  out  1  instruction may complete this cycle.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse (state == DONE).
- `is_dev_op`  out  1  combinational: opcode maps to a channel.
- `cur_ch`  out  CH_W  channel of the operation in progress; held after completion.
- `stall_cnt`  out  STAT_W  saturating count of cycles with `is_act`=1 and `ready`=0.

## Operation
- Decode: channel 0 = HDTOINST 6'b100011, HDTOREG 6'b100100, REGTOHD 6'b100101. Channels 1..N_CH-1 come from the package opcode table; unmapped opcodes give `is_dev_op`=0.
- Latency registers `lat[N_CH]`:
  - Written when `cfg_we`=1, in any state.
  - A start in the same cycle uses the old value; the new value applies from the next start.
  - `cfg_ch` >= N_CH: write ignored.
- FSM, states IDLE, WAIT, DONE. Let L = max(lat[ch], 1).
  - IDLE: `ready` = !(is_act & is_dev_op), combinational. On is_act & is_dev_op: latch `cur_ch`, `cnt` <= L-1. Go to DONE if L==1, else to WAIT.
  - WAIT: `ready`=0. If `cnt`==1, go to DONE; else `cnt` <= `cnt`-1.
  - DONE: `ready`=1, `done`=1 for exactly one cycle, then IDLE unconditionally.
- Back-to-back device ops: the second op is seen in IDLE the cycle after DONE and starts a fresh count. No spurious ready in between, because IDLE's ready is combinational on `is_dev_op`.
- Abort: `is_act`=0 in any state gives next state IDLE, `cnt`=0, `ready`=1 immediately (combinational), `done`=0.
- `stall_cnt`:
  - Increments each cycle `is_act`=1 and `ready`=0.
  - Saturates at all-ones.
  - `stat_clr` has priority over increment.

## Timing
- Reset values: state IDLE, `cnt`=0, `cur_ch`=0, `stall_cnt`=0, lat[0]=HD_LAT, others DEF_LAT.
- Reset output values: `busy`=0, `done`=0; `ready`=1 unless is_act & is_dev_op.
- Device op first presented in cycle 0 gives `ready` low for cycles 0..L-1 and high in cycle L (DONE). Total stall is exactly L cycles.
- `rst_n` deassertion mid-op: no resume; the op restarts from IDLE if the opcode is still present.
- `opcode` change during WAIT is ignored; the latched channel and count continue.
- `cnt` never wraps: it is loaded with L-1 <= 2^LAT_W-2 and only decremented while >1.

## Structure
- `dev_timer_pkg`:
  - opcode localparams (HDTOINST, HDTOREG, REGTOHD).
  - channel opcode table.
  - state enum {IDLE, WAIT, DONE}.
  - `CH_HD`=0.
- Sub-module `dev_op_decode`: opcode to {is_dev_op, ch}, purely combinational, reusable by the decoder.
- `dev_timer`: latency register file, FSM, counter, statistic.

## Test plan
- Reset, is_act=1, opcode=6'b100011 held -> `ready` low for exactly 4 cycles, `done` pulse in cycle 4, `stall_cnt`=4, `cur_ch`=0.
- cfg_we ch0 lat=1, then HDTOREG -> `ready` low 1 cycle, DONE next. Then cfg_lat=0 -> identical behaviour (treated as 1).
- Two consecutive REGTOHD instructions, L=3 -> low 3 cycles, high 1, low 3, high 1; `stall_cnt`=6.
- is_act dropped in the 2nd WAIT cycle of an L=8 op -> `ready`=1 the same cycle, `busy`=0 next cycle, no `done`. Re-asserted with op still present -> full 8-cycle count again.
- cfg_we to ch0 with lat=10 in the start cycle (old lat 4) -> this op stalls 4 cycles; the next op stalls 10.
- STAT_W=4, 20 stall cycles -> `stall_cnt` saturates at 15. `stat_clr` together with a stall cycle -> 0.
